// File: rtl/operand_fetch_pkg.sv
// Shared widths and helpers for the ONC-16 operand fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W     = 16;
  localparam int RF_ADDR_W  = 4;
  localparam int RF_NUM     = 2**RF_ADDR_W;
  localparam int OF_STALL_W = 16;

  typedef logic [OF_STALL_W-1:0] stall_cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic stall_cnt_t satInc(input stall_cnt_t value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-to-fetch instruction handshake and fetch-to-execute operand bundle.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W    = operand_fetch_pkg::DATA_W,
  parameter int RF_ADDR_W = operand_fetch_pkg::RF_ADDR_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [RF_ADDR_W-1:0] in_rs1;
  logic [RF_ADDR_W-1:0] in_rs2;
  logic [RF_ADDR_W-1:0] in_rd;
  logic                 in_use_rs1;
  logic                 in_use_rs2;
  logic                 in_use_rd;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_op1;
  logic [DATA_W-1:0]    out_op2;
  logic [RF_ADDR_W-1:0] out_rd;
  logic                 out_use_rd;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_use_rd, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_rd, out_use_rd
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_use_rd, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_rd, out_use_rd
  );

endinterface

// File: rtl/operand_fetch_rf_scoreboard.sv
// Per-register pending-write scoreboard with same-cycle-clear aware lookups.
module rf_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int RF_ADDR_W = operand_fetch_pkg::RF_ADDR_W
)(
  input  logic                        clock,
  input  logic                        n_rst,
  input  logic                        set_en,
  input  logic [RF_ADDR_W-1:0]        set_addr,
  input  logic                        clr_en,
  input  logic [RF_ADDR_W-1:0]        clr_addr,
  input  logic [2:0][RF_ADDR_W-1:0]   look_addr,
  output logic [2:0]                  look_eb,
  output logic [2**RF_ADDR_W-1:0]     busy_vec
);

  localparam int NUM = 2**RF_ADDR_W;

  logic [NUM-1:0] busy_q;
  logic [NUM-1:0] busy_d;
  logic [NUM-1:0] clr_vec;

  // The set is applied after the clear so a new producer wins over a retiring one.
  always_comb begin
    clr_vec = '0;
    if (clr_en) clr_vec[clr_addr] = 1'b1;
    busy_d = busy_q & ~clr_vec;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_comb begin
    look_eb = '0;
    for (int i = 0; i < 3; i++) begin
      look_eb[i] = busy_q[look_addr[i]] && !clr_vec[look_addr[i]];
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read, writeback bypass, hazard stall and output register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W    = operand_fetch_pkg::DATA_W,
  parameter int RF_ADDR_W = operand_fetch_pkg::RF_ADDR_W
)(
  input  logic                    clock,
  input  logic                    n_rst,
  operand_fetch_if.slave          fetch_if,
  output logic [RF_ADDR_W-1:0]    r1_addr,
  output logic [RF_ADDR_W-1:0]    r2_addr,
  input  logic [DATA_W-1:0]       r1_data,
  input  logic [DATA_W-1:0]       r2_data,
  input  logic                    wb_we,
  input  logic [RF_ADDR_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  output logic [2**RF_ADDR_W-1:0] busy_vec,
  output logic [OF_STALL_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]    op1;
    logic [DATA_W-1:0]    op2;
    logic [RF_ADDR_W-1:0] rd;
    logic                 use_rd;
  } bundle_t;

  bundle_t    bundle_q, bundle_d;
  logic       valid_q, valid_d;
  stall_cnt_t stall_q, stall_d;
  logic [2:0] eb;
  logic       hazard;
  logic       accept;

  assign r1_addr = fetch_if.in_rs1;
  assign r2_addr = fetch_if.in_rs2;

  rf_scoreboard #(.RF_ADDR_W(RF_ADDR_W)) u_scoreboard (
    .clock     (clock),
    .n_rst     (n_rst),
    .set_en    (accept && fetch_if.in_use_rd),
    .set_addr  (fetch_if.in_rd),
    .clr_en    (wb_we),
    .clr_addr  (wb_addr),
    .look_addr ({fetch_if.in_rd, fetch_if.in_rs2, fetch_if.in_rs1}),
    .look_eb   (eb),
    .busy_vec  (busy_vec)
  );

  assign hazard = fetch_if.in_valid &&
                  ((fetch_if.in_use_rs1 && eb[0]) ||
                   (fetch_if.in_use_rs2 && eb[1]) ||
                   (fetch_if.in_use_rd  && eb[2]));

  assign fetch_if.in_ready = (!valid_q || fetch_if.out_ready) && !hazard;
  assign accept            = fetch_if.in_valid && fetch_if.in_ready;

  // The register file writes on the clock edge, so a writeback in flight must be forwarded.
  always_comb begin
    bundle_d = bundle_q;
    valid_d  = valid_q;
    stall_d  = hazard ? satInc(stall_q) : stall_q;
    if (accept) begin
      bundle_d.op1    = (wb_we && wb_addr == fetch_if.in_rs1) ? wb_data : r1_data;
      bundle_d.op2    = (wb_we && wb_addr == fetch_if.in_rs2) ? wb_data : r2_data;
      bundle_d.rd     = fetch_if.in_rd;
      bundle_d.use_rd = fetch_if.in_use_rd;
      valid_d         = 1'b1;
    end else if (fetch_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      bundle_q <= '0;
      valid_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
    end
  end

  assign fetch_if.out_valid  = valid_q;
  assign fetch_if.out_op1    = bundle_q.op1;
  assign fetch_if.out_op2    = bundle_q.op2;
  assign fetch_if.out_rd     = bundle_q.rd;
  assign fetch_if.out_use_rd = bundle_q.use_rd;
  assign stall_cnt           = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios then randomized traffic against a reference model.
module tb_operand_fetch;

  logic        clock;
  logic        nRst;
  logic [3:0]  r1Addr, r2Addr;
  logic [15:0] r1Data, r2Data;
  logic        wbWe;
  logic [3:0]  wbAddr;
  logic [15:0] wbData;
  logic [15:0] busyVec;
  logic [15:0] stallCnt;

  logic [15:0] rf [16];

  logic        mValid;
  logic [15:0] mOp1, mOp2;
  logic [3:0]  mRd;
  logic        mUseRd;
  bit          mPend [16];
  int          mStall;

  int checkCount;
  int passCount;

  operand_fetch_if ofIf ();

  operand_fetch dut (
    .clock     (clock),
    .n_rst     (nRst),
    .fetch_if  (ofIf),
    .r1_addr   (r1Addr),
    .r2_addr   (r2Addr),
    .r1_data   (r1Data),
    .r2_data   (r2Data),
    .wb_we     (wbWe),
    .wb_addr   (wbAddr),
    .wb_data   (wbData),
    .busy_vec  (busyVec),
    .stall_cnt (stallCnt)
  );

  assign r1Data = rf[r1Addr];
  assign r2Data = rf[r2Addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic [3:0] rd, input logic u1, input logic u2, input logic ud,
                               input logic we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic ordy);
    ofIf.in_valid   = v;
    ofIf.in_rs1     = rs1;
    ofIf.in_rs2     = rs2;
    ofIf.in_rd      = rd;
    ofIf.in_use_rs1 = u1;
    ofIf.in_use_rs2 = u2;
    ofIf.in_use_rd  = ud;
    wbWe            = we;
    wbAddr          = wa;
    wbData          = wd;
    ofIf.out_ready  = ordy;
  endtask

  function automatic bit pendingNow(input logic [3:0] a);
    return mPend[a] && !(wbWe && wbAddr == a);
  endfunction

  function automatic logic [15:0] pendVector();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i] = mPend[i];
    return v;
  endfunction

  task automatic resetModel();
    mValid = 1'b0;
    mOp1   = '0;
    mOp2   = '0;
    mRd    = '0;
    mUseRd = 1'b0;
    mStall = 0;
    for (int i = 0; i < 16; i++) mPend[i] = 1'b0;
  endtask

  task automatic checkRegistered(input string phase);
    checkOutput({phase, "OutValid"}, ofIf.out_valid, mValid);
    checkOutput({phase, "Op1"}, ofIf.out_op1, mOp1);
    checkOutput({phase, "Op2"}, ofIf.out_op2, mOp2);
    checkOutput({phase, "Rd"}, ofIf.out_rd, mRd);
    checkOutput({phase, "UseRd"}, ofIf.out_use_rd, mUseRd);
    checkOutput({phase, "Busy"}, busyVec, pendVector());
    checkOutput({phase, "Stall"}, stallCnt, mStall);
  endtask

  // One clock: check the combinational handshake, advance the model, check registered state.
  task automatic stepCycle();
    bit          stalled, ready, take;
    logic [15:0] nextOp1, nextOp2;
    #1;
    stalled = ofIf.in_valid && ((ofIf.in_use_rs1 && pendingNow(ofIf.in_rs1)) ||
                                (ofIf.in_use_rs2 && pendingNow(ofIf.in_rs2)) ||
                                (ofIf.in_use_rd  && pendingNow(ofIf.in_rd)));
    ready   = (!mValid || ofIf.out_ready) && !stalled;
    take    = ofIf.in_valid && ready;
    checkOutput("inReady", ofIf.in_ready, ready);
    checkOutput("r1Addr", r1Addr, ofIf.in_rs1);
    checkOutput("r2Addr", r2Addr, ofIf.in_rs2);
    nextOp1 = (wbWe && wbAddr == ofIf.in_rs1) ? wbData : rf[ofIf.in_rs1];
    nextOp2 = (wbWe && wbAddr == ofIf.in_rs2) ? wbData : rf[ofIf.in_rs2];
    @(posedge clock);
    if (stalled && mStall < 65535) mStall++;
    if (wbWe) mPend[wbAddr] = 1'b0;
    if (take) begin
      mValid = 1'b1;
      mOp1   = nextOp1;
      mOp2   = nextOp2;
      mRd    = ofIf.in_rd;
      mUseRd = ofIf.in_use_rd;
      if (ofIf.in_use_rd) mPend[ofIf.in_rd] = 1'b1;
    end else if (ofIf.out_ready) begin
      mValid = 1'b0;
    end
    #1;
    if (wbWe) rf[wbAddr] = wbData;
    checkRegistered("cyc");
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h0101);
    rf[1] = 16'h1111;
    rf[2] = 16'h2222;
    rf[3] = 16'h1234;
    rf[5] = 16'hABCD;
    resetModel();
    nRst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1);

    #2;
    checkRegistered("reset");
    #1 nRst = 1'b1;
    stepCycle();
    stepCycle();

    $display("[TB] plain fetch");
    applyStimulus(1, 3, 5, 7, 1, 1, 1, 0, 0, 16'h0, 1);
    stepCycle();
    checkOutput("plainOp1", ofIf.out_op1, 16'h1234);
    checkOutput("plainOp2", ofIf.out_op2, 16'hABCD);
    checkOutput("plainRd", ofIf.out_rd, 4'd7);
    checkOutput("plainBusy", busyVec, 16'h0080);

    $display("[TB] RAW stall and bypass release");
    applyStimulus(1, 7, 0, 0, 1, 0, 0, 0, 0, 16'h0, 1);
    repeat (3) stepCycle();
    checkOutput("rawStallCnt", stallCnt, 16'd3);
    applyStimulus(1, 7, 0, 0, 1, 0, 0, 1, 7, 16'h8000, 1);
    #1 checkOutput("rawReleaseReady", ofIf.in_ready, 1'b1);
    stepCycle();
    checkOutput("rawBypassOp1", ofIf.out_op1, 16'h8000);
    checkOutput("rawBusyClear", busyVec, 16'h0000);

    $display("[TB] same-cycle set and clear");
    applyStimulus(1, 1, 2, 8, 1, 1, 1, 0, 0, 16'h0, 1);
    stepCycle();
    applyStimulus(1, 3, 5, 8, 0, 0, 1, 1, 8, 16'h5555, 1);
    stepCycle();
    checkOutput("setWinsBit8", busyVec[8], 1'b1);

    $display("[TB] backpressure");
    applyStimulus(1, 1, 2, 4, 1, 1, 1, 0, 0, 16'h0, 0);
    repeat (5) stepCycle();
    checkOutput("bpOp1Held", ofIf.out_op1, 16'h1234);
    checkOutput("bpOp2Held", ofIf.out_op2, 16'hABCD);
    checkOutput("bpStallHeld", stallCnt, 16'd3);
    applyStimulus(1, 1, 2, 4, 1, 1, 1, 0, 0, 16'h0, 1);
    stepCycle();
    checkOutput("bpLoadOp1", ofIf.out_op1, 16'h1111);
    checkOutput("bpLoadOp2", ofIf.out_op2, 16'h2222);
    checkOutput("bpBusy", busyVec, 16'h0110);

    $display("[TB] reset mid-flight");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    #2 nRst = 1'b0;
    #1;
    resetModel();
    checkOutput("midRstBusy", busyVec, 16'h0000);
    checkOutput("midRstValid", ofIf.out_valid, 1'b0);
    #1 nRst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4, 16'h4444, 1);
    stepCycle();
    checkOutput("wbNotBusy", busyVec, 16'h0000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), 16'($urandom),
                    1'($urandom_range(0, 3) != 0));
      stepCycle();
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side initiator for the 16-entry register file: drives `r1_addr`/`r2_addr`, captures `r1_data`/`r2_data`, and registers two operands for the execute stage.
- Contains a per-register busy scoreboard that stalls on RAW/WAW hazards against outstanding writebacks.
- Bypasses a same-cycle writeback, because the register file writes synchronously and would otherwise return the stale value.
- Sits between decode and execute in the ONC-16 pipeline.

Parameters:
- DATA_W, 16, operand and register width.
- RF_ADDR_W, 4, register address width; the file holds 2**RF_ADDR_W registers.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_rs1  in  RF_ADDR_W  source 1 register.
- in_rs2  in  RF_ADDR_W  source 2 register.
- in_rd  in  RF_ADDR_W  destination register.
- in_use_rs1  in  1  rs1 is read.
- in_use_rs2  in  1  rs2 is read.
- in_use_rd  in  1  rd will be written back.
- r1_addr  out  RF_ADDR_W  register file read port 1 address.
- r2_addr  out  RF_ADDR_W  register file read port 2 address.
- r1_data  in  DATA_W  register file read port 1 data (asynchronous read).
- r2_data  in  DATA_W  register file read port 2 data (asynchronous read).
- wb_we  in  1  writeback this cycle; the same signal drives the register file `we`.
- wb_addr  in  RF_ADDR_W  writeback register.
- wb_data  in  DATA_W  writeback data.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_op1  out  DATA_W  operand 1.
- out_op2  out  DATA_W  operand 2.
- out_rd  out  RF_ADDR_W  destination, passed through.
- out_use_rd  out  1  writeback flag, passed through.
- busy_vec  out  2**RF_ADDR_W  scoreboard bits; bit n means register n has a pending write.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Reset is asynchronous and active-low. While n_rst = 0: out_valid = 0, out_op1 = out_op2 = 0, out_rd = 0, out_use_rd = 0, busy_vec = 0, stall_cnt = 0.
- Reset mid-operation discards the held bundle and clears every busy bit. A later wb for a register that is not busy is a no-op on the scoreboard.
- Addressing is combinational: r1_addr = in_rs1, r2_addr = in_rs2, regardless of valid.
- Clearing a busy bit this cycle: clr(n) = wb_we && wb_addr == n.
- Effective busy: eb(n) = busy_vec[n] && !clr(n).
- hazard = in_valid && ((in_use_rs1 && eb(in_rs1)) || (in_use_rs2 && eb(in_rs2)) || (in_use_rd && eb(in_rd))).
- No register is hardwired to zero; register 0 is general purpose.
- in_ready = (!out_valid || out_ready) && !hazard. It is combinational on in_*, wb_*, out_ready and state.
- Operand select for op1: wb_data if (wb_we && wb_addr == in_rs1), else r1_data. op2 is selected the same way from wb_data/r2_data. If in_use_rsX = 0, the captured value is don't-care; the block captures the mux result anyway.
- Accept (in_valid && in_ready): next edge loads out_op1, out_op2, out_rd, out_use_rd and sets out_valid = 1. Latency is 1 cycle from accept to out_valid.
- No accept and out_ready = 1: out_valid becomes 0 and data registers hold.
- out_valid && !out_ready: all out_* hold stable (no bubble insertion, no overwrite).
- Full-throughput back-to-back accepts are supported when out_ready stays high.
- Scoreboard per register n, next state:
  - Set when (accept && in_use_rd && in_rd == n).
  - Else clear when clr(n).
  - Else hold.
  - Set and clear on the same n in one cycle: set wins (the new producer).
- stall_cnt increments when in_valid && hazard, and saturates at 16'hFFFF. It does not count backpressure-only stalls (out_valid && !out_ready && !hazard).
- Operand values held in the output register are never updated by a later writeback. Hazard rules guarantee they are already current.

Decomposition:
- Shared definitions file (def.v) gains RF_NUM = 2**RF_ADDR_W alongside the existing DATA_W and RF_ADDR_W. Stall counter width is fixed at 16 (OF_STALL_W).
- Sub-module `rf_scoreboard`:
  - Inputs: clock, n_rst, set_en, set_addr, clr_en, clr_addr.
  - Output: busy_vec.
  - Provides an eb() lookup for three addresses.
- The top level holds the bypass muxes, handshake and output register. Instantiate it with the register file in the system test.

Test Plan:
- Reset then idle: n_rst low for 2 ns → all outputs 0, busy_vec = 0. Release, in_valid = 0 → out_valid stays 0.
- Plain fetch: the register file is preloaded with R3 = 16'h1234 and R5 = 16'hABCD. Issue rs1 = 3, rs2 = 5, rd = 7, use all, out_ready = 1 → next cycle out_op1 = 1234, out_op2 = ABCD, out_rd = 7. busy_vec = 16'h0080.
- RAW stall and release: with R7 busy, issue rs1 = 7. Hold for 3 cycles with no wb → in_ready = 0, stall_cnt = 3. Then a wb cycle wb_we = 1, wb_addr = 7, wb_data = 16'h8000 → same-cycle accept, out_op1 = 8000 (bypass), busy_vec bit 7 cleared.
- Same-cycle set/clear: R8 busy; wb to 8 coincides with accept of an instruction with rd = 8 → busy_vec bit 8 remains 1.
- Backpressure: out_ready = 0 with out_valid = 1 and a new in_valid → in_ready = 0 and out_op1/out_op2 unchanged for 5 cycles; stall_cnt unchanged. Raise out_ready → the new bundle loads next edge.
- Reset mid-flight: busy_vec = 16'h0110 and out_valid = 1, pulse n_rst low asynchronously mid-cycle → busy_vec = 0 and out_valid = 0 immediately. A subsequent wb to 4 leaves busy_vec at 0.
